register_file: RTL and testbench
================================

Name: register_file

Overview:
- 32 x 32-bit RV32I integer register file with one write port (write_n/in protocol) and two combinational read ports.
- x0 is hardwired to zero.
- Adds a debug dump reader: on request, it streams all 32 registers out one per handshake.
- Sits between the decode/writeback stages; the dump port feeds the testbench or debug monitor.

Parameters:
- NREG, 32, number of registers (power of two; index width = log2(NREG)).
- WIDTH, 32, register data width.
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-low reset.
- write_n  input  1  active-low write enable, sampled at the clk rising edge.
- wa  input  5  write address.
- in  input  WIDTH  write data.
- ra1  input  5  read address, port 1.
- ra2  input  5  read address, port 2.
- out1  output  WIDTH  read data, port 1 (combinational).
- out2  output  WIDTH  read data, port 2 (combinational).
- dump_start  input  1  one-cycle request to start a dump.
- dump_valid  output  1  dump_data/dump_idx are valid.
- dump_ready  input  1  consumer accepts the current dump beat.
- dump_idx  output  5  register index of the current beat.
- dump_data  output  WIDTH  register value of the current beat.
- dump_busy  output  1  high from acceptance of dump_start until the last beat is accepted.
- dump_done  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (rst=0, asynchronous): all registers become 0.
  - FSM goes to IDLE.
  - dump_valid=0, dump_busy=0, dump_done=0, dump_idx=0, dump_data=0.
  - out1/out2 read 0.
- Write: at clk rising edge, if write_n=0 and wa!=0, reg[wa]<=in; otherwise the register holds its value. Writes with wa=0 are discarded.
- Read: outN = 0 if raN=0; otherwise:
  - BYPASS=1 with write_n=0 and wa=raN: outN = in.
  - Otherwise outN = reg[raN].
  - Zero latency. Both ports are independent and may hold the same address.
- Dump FSM states are IDLE and SEND.
  - IDLE: dump_valid=0. When dump_start=1 at a clk edge, go to SEND. Load dump_idx=0 and dump_data=0 (x0). Set dump_busy=1.
  - SEND: dump_valid=1. dump_idx and dump_data hold stable while dump_ready=0. On an edge with dump_ready=1 and dump_idx<31:
    - dump_idx increments.
    - dump_data loads the value of the new index as visible after that edge, i.e. including any write committed at the same edge (forward in when write_n=0 and wa equals the new index).
  - SEND, final beat: on an edge with dump_ready=1 and dump_idx=31, go to IDLE. dump_valid=0 and dump_busy=0 next cycle; dump_done=1 for exactly that one cycle.
  - Writes to a register after its beat is loaded are not reflected in that beat: the beat is a snapshot.
- dump_start while busy is ignored. dump_start in the same cycle as the dump_done pulse starts a new dump.
- Reset mid-dump aborts immediately: dump_valid=0 and no dump_done pulse.
- Normal reads and writes are unaffected by dump activity.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5 and XLEN=32.
  - The dump FSM state enum {IDLE, SEND}.
  - The x0 index constant.
- One natural sub-module: regfile_dump_ctrl (the FSM plus the index counter and snapshot register), reading storage through an internal read port.

Test Plan:
1. Reset with rst low, then high; read ra1=5, ra2=31 -> out1=0, out2=0. Attempt a write to wa=0 with in=99, then read ra1=0 -> 0.
2. write_n=0, wa=3, in=123, ra1=3 in the same cycle:
   - BYPASS=1: out1=123 before the edge.
   - BYPASS=0: out1=0 before the edge, 123 after.
   - Next cycle with write_n=1 and in=0 -> out1 stays 123.
3. Write 546 to x7, then pulse rst low for 5 ns with no clock -> out for x7 reads 0 immediately.
4. Preload reg[i]=i*10 for i=1..31, pulse dump_start, hold dump_ready=1:
   - 32 consecutive beats idx 0..31 with data 0,10,...,310.
   - dump_done pulses once; dump_busy falls on the same cycle dump_valid drops.
5. Dump with dump_ready toggling 1-0-1 and a write of 777 to x5 while beat idx=5 is stalled:
   - Beat 5 data stays at its snapshot value (50), stable throughout the stall.
   - A write of 888 to x6 on the edge that advances to idx 6 -> beat 6 data = 888.
6. rst low during beat idx=12 -> dump_valid=0, no dump_done. A subsequent dump_start restarts at idx 0 with all-zero data.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared constants and types for the RV32I register file and its debug dump port.
package register_file_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } dump_state_e;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Dump sequencer: walks the register file one beat per handshake, snapshotting each value on load.
module regfile_dump_ctrl
    import register_file_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int WIDTH = XLEN,
    parameter int AW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dump_start,
    input  logic             dump_ready,
    output logic [AW-1:0]    rd_idx,
    input  logic [WIDTH-1:0] rd_data,
    output logic             dump_valid,
    output logic [AW-1:0]    dump_idx,
    output logic [WIDTH-1:0] dump_data,
    output logic             dump_busy,
    output logic             dump_done
);

    dump_state_e state, state_nx;
    logic        last;

    assign last   = (dump_idx == AW'(NREG - 1));
    // Index being loaded on the next accepted beat; the top forwards same-edge writes into it.
    assign rd_idx = dump_idx + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        dump_valid = 1'b0;
        dump_busy  = 1'b0;
        case (state)
            IDLE: if (dump_start) state_nx = SEND;
            SEND: begin
                dump_valid = 1'b1;
                dump_busy  = 1'b1;
                if (dump_ready && last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dump_idx  <= '0;
            dump_data <= '0;
            dump_done <= 1'b0;
        end else begin
            dump_done <= 1'b0;
            case (state)
                IDLE: if (dump_start) begin
                    dump_idx  <= AW'(X0);
                    dump_data <= '0;
                end
                SEND: if (dump_ready) begin
                    if (last) begin
                        dump_done <= 1'b1;
                    end else begin
                        dump_idx  <= rd_idx;
                        dump_data <= rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/register_file.sv
// RV32I integer register file: one write port, two combinational read ports, x0 tied to zero, debug dump.
module register_file
    import register_file_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int WIDTH  = XLEN,
    parameter bit BYPASS = 1'b1,
    parameter int AW     = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write_n,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] in,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    input  logic             dump_start,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [AW-1:0]    dump_idx,
    output logic [WIDTH-1:0] dump_data,
    output logic             dump_busy,
    output logic             dump_done
);

    logic [WIDTH-1:0] regs [NREG];
    logic [AW-1:0]    dump_rd_idx;
    logic [WIDTH-1:0] dump_rd_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (!write_n && wa != AW'(X0)) begin
            regs[wa] <= in;
        end
    end

    // fwd selects whether an in-flight write is visible to this reader.
    function automatic logic [WIDTH-1:0] rd_port(input logic [AW-1:0] a, input logic fwd);
        if (a == AW'(X0))                return '0;
        if (fwd && !write_n && wa == a)  return in;
        return regs[a];
    endfunction

    assign out1 = rd_port(ra1, BYPASS);
    assign out2 = rd_port(ra2, BYPASS);

    // The dump beat must reflect the post-edge value, so it always forwards.
    assign dump_rd_data = rd_port(dump_rd_idx, 1'b1);

    regfile_dump_ctrl #(
        .NREG  (NREG),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_dump (
        .clk        (clk),
        .rst        (rst),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .rd_idx     (dump_rd_idx),
        .rd_data    (dump_rd_data),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );

endmodule

// File: tb/tb_register_file.sv
// Randomized bench for register_file against an array/scoreboard model of the register and dump rules.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_n;
    logic [4:0]  wa, ra1, ra2;
    logic [31:0] wdata;
    logic        dump_start, dump_ready;
    logic [31:0] out1, out2, out1_nb, out2_nb;
    logic        dump_valid, dump_busy, dump_done;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;
    logic        nb_valid, nb_busy, nb_done;
    logic [4:0]  nb_idx;
    logic [31:0] nb_data;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] mdl [32];
    logic        m_busy, m_done;
    int          m_idx;
    logic [31:0] m_data;

    always #10 clk = ~clk;

    register_file #(.BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .write_n(write_n), .wa(wa), .in(wdata),
        .ra1(ra1), .ra2(ra2), .out1(out1), .out2(out2),
        .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_idx(dump_idx), .dump_data(dump_data), .dump_busy(dump_busy), .dump_done(dump_done)
    );

    register_file #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .write_n(write_n), .wa(wa), .in(wdata),
        .ra1(ra1), .ra2(ra2), .out1(out1_nb), .out2(out2_nb),
        .dump_start(dump_start), .dump_valid(nb_valid), .dump_ready(dump_ready),
        .dump_idx(nb_idx), .dump_data(nb_data), .dump_busy(nb_busy), .dump_done(nb_done)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at %0t", tag, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && !write_n && wa == a) return wdata;
        return mdl[a];
    endfunction

    task automatic check_reads();
        #1;
        chk("out1", out1, exp_rd(ra1, 1'b1));
        chk("out2", out2, exp_rd(ra2, 1'b1));
        chk("out1_nb", out1_nb, exp_rd(ra1, 1'b0));
        chk("out2_nb", out2_nb, exp_rd(ra2, 1'b0));
    endtask

    task automatic chk_dump();
        chk("dump_valid", dump_valid, m_busy);
        chk("dump_busy", dump_busy, m_busy);
        chk("dump_done", dump_done, m_done);
        chk("nb_done", nb_done, m_done);
        if (m_busy) begin
            chk("dump_idx", dump_idx, m_idx);
            chk("dump_data", dump_data, m_data);
        end
    endtask

    // One clock: apply the architectural rules to the model at the edge, then check dump outputs.
    task automatic cyc();
        logic adv;
        @(posedge clk);
        adv    = 1'b0;
        m_done = 1'b0;
        if (m_busy) begin
            if (dump_ready) begin
                if (m_idx == 31) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end else begin
                    m_idx++;
                    adv = 1'b1;
                end
            end
        end else if (dump_start) begin
            m_busy = 1'b1;
            m_idx  = 0;
            m_data = 32'd0;
        end
        if (!write_n && wa != 5'd0) mdl[wa] = wdata;
        if (adv) m_data = mdl[m_idx];
        @(negedge clk);
        chk_dump();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        m_busy = 1'b0;
        m_done = 1'b0;
        m_idx  = 0;
        m_data = 32'd0;
    endtask

    // Asynchronous reset pulse placed between clock edges (called right after a negedge).
    task automatic pulse_rst();
        write_n = 1'b1;
        #2 rst = 1'b0;
        model_reset();
        #3;
        chk("rst_out1", out1, 32'd0);
        chk("rst_out2", out2, 32'd0);
        chk("rst_valid", dump_valid, 1'b0);
        chk("rst_busy", dump_busy, 1'b0);
        chk("rst_done", dump_done, 1'b0);
        chk("rst_idx", dump_idx, 32'd0);
        chk("rst_data", dump_data, 32'd0);
        #2 rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, nd;
        logic seen;
        rst = 1'b0; write_n = 1'b1; wa = '0; wdata = '0; ra1 = '0; ra2 = '0;
        dump_start = 1'b0; dump_ready = 1'b0;
        model_reset();
        @(negedge clk);
        chk("reset_valid", dump_valid, 1'b0);
        chk("reset_idx", dump_idx, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // 1: reset reads, write to x0 discarded
        ra1 = 5'd5; ra2 = 5'd31;
        check_reads();
        chk("t1_out1", out1, 32'd0);
        chk("t1_out2", out2, 32'd0);
        write_n = 1'b0; wa = 5'd0; wdata = 32'd99; ra1 = 5'd0;
        check_reads();
        cyc();
        write_n = 1'b1;
        check_reads();
        chk("t1_x0", out1, 32'd0);

        // 2: same-cycle bypass vs no bypass
        write_n = 1'b0; wa = 5'd3; wdata = 32'd123; ra1 = 5'd3;
        check_reads();
        chk("t2_byp_pre", out1, 32'd123);
        chk("t2_nobyp_pre", out1_nb, 32'd0);
        cyc();
        write_n = 1'b1; wdata = 32'd0;
        check_reads();
        chk("t2_byp_post", out1, 32'd123);
        chk("t2_nobyp_post", out1_nb, 32'd123);

        // 3: async reset clears storage
        write_n = 1'b0; wa = 5'd7; wdata = 32'd546;
        cyc();
        write_n = 1'b1; ra1 = 5'd7;
        check_reads();
        chk("t3_pre", out1, 32'd546);
        @(negedge clk);
        pulse_rst();
        check_reads();
        chk("t3_post", out1, 32'd0);

        // 4: full dump of i*10
        for (int i = 1; i < 32; i++) begin
            write_n = 1'b0; wa = 5'(i); wdata = 32'(i * 10);
            cyc();
        end
        write_n = 1'b1;
        dump_start = 1'b1; dump_ready = 1'b1;
        cyc();
        dump_start = 1'b0;
        nb = 0; nd = 0;
        for (int c = 0; c < 40 && nd == 0; c++) begin
            if (dump_valid) begin
                chk("t4_idx", dump_idx, nb);
                chk("t4_data", dump_data, nb * 10);
                nb++;
            end
            cyc();
            if (dump_done) nd++;
        end
        cyc();
        if (dump_done) nd++;
        chk("t4_beats", nb, 32);
        chk("t4_done_cnt", nd, 1);

        // 5: stall on beat 5 with a write to x5, then forward a write into beat 6
        dump_start = 1'b1; dump_ready = 1'b1;
        cyc();
        dump_start = 1'b0;
        dump_ready = 1'b0; cyc();
        dump_ready = 1'b1;
        for (int c = 0; c < 40 && m_idx != 5; c++) cyc();
        chk("t5_at5", dump_idx, 32'd5);
        dump_ready = 1'b0; write_n = 1'b0; wa = 5'd5; wdata = 32'd777;
        cyc();
        chk("t5_snap_a", dump_data, 32'd50);
        write_n = 1'b1; ra1 = 5'd5;
        check_reads();
        chk("t5_x5", out1, 32'd777);
        cyc();
        chk("t5_snap_b", dump_data, 32'd50);
        chk("t5_idx_b", dump_idx, 32'd5);
        dump_ready = 1'b1; write_n = 1'b0; wa = 5'd6; wdata = 32'd888;
        cyc();
        chk("t5_idx6", dump_idx, 32'd6);
        chk("t5_fwd6", dump_data, 32'd888);
        write_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            dump_ready = c[0];
            cyc();
            if (dump_done) seen = 1'b1;
        end
        chk("t5_done", seen, 1'b1);

        // 6: reset during beat 12 aborts; restart yields zeros
        dump_ready = 1'b1; dump_start = 1'b1;
        cyc();
        dump_start = 1'b0;
        for (int c = 0; c < 40 && m_idx != 12; c++) cyc();
        chk("t6_at12", dump_idx, 32'd12);
        pulse_rst();
        chk("t6_valid", dump_valid, 1'b0);
        cyc(); cyc();
        dump_start = 1'b1;
        cyc();
        dump_start = 1'b0;
        chk("t6_idx0", dump_idx, 32'd0);
        chk("t6_data0", dump_data, 32'd0);
        for (int c = 0; c < 40 && m_busy; c++) cyc();
        chk("t6_finished", m_busy, 1'b0);
        cyc();

        // Random traffic: reads, writes, dumps and back-pressure against the model
        for (int c = 0; c < 600; c++) begin
            write_n    = 1'($urandom_range(0, 1));
            wa         = 5'($urandom_range(0, 31));
            wdata      = $urandom;
            ra1        = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ra2        = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            dump_start = ($urandom_range(0, 15) == 0);
            dump_ready = ($urandom_range(0, 3) != 0);
            if (m_busy && ($urandom_range(0, 2) == 0)) wa = 5'(m_idx + 1);
            check_reads();
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
